// File: rtl/uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_sched
// Function : Round-robin scheduler giving four requesters turns on a single
//            UART transmitter, with a per-byte completion timeout.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_sched #(
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  gnt,
  output logic [3:0]  done,
  output logic [3:0]  err,
  output logic        active,
  input  logic        tx_busy,
  input  logic        tx_end,
  output logic        tx_start,
  output logic [7:0]  tx_data
);

  localparam logic [15:0] c_TMO_LAST = TIMEOUT - 16'd1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t      r_state;
  logic [3:0]  r_gnt;
  logic [3:0]  r_done;
  logic [3:0]  r_err;
  logic        r_active;
  logic        r_tx_start;
  logic [7:0]  r_tx_data;
  logic [15:0] r_cnt;
  logic [1:0]  r_last;

  logic [1:0]  w_winner;
  logic [1:0]  w_idx;
  logic [7:0]  w_byte;

  // Scan offsets 4..1 from the last owner so the smallest offset is written last and wins.
  always_comb begin
    w_winner = r_last;
    w_idx    = r_last;
    for (int i = 3; i >= 0; i--) begin
      w_idx = r_last + 2'(i + 1);
      if (req[w_idx]) w_winner = w_idx;
    end
  end

  assign w_byte = req_data[{w_winner, 3'b000} +: 8];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_gnt      <= 4'b0000;
      r_done     <= 4'b0000;
      r_err      <= 4'b0000;
      r_active   <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_cnt      <= 16'd0;
      r_last     <= 2'd3;
    end else begin
      r_tx_start <= 1'b0;
      r_tx_data  <= 8'h00;
      r_done     <= 4'b0000;
      r_err      <= 4'b0000;
      case (r_state)
        S_IDLE: begin
          if (en && !tx_busy && (req != 4'b0000)) begin
            r_state    <= S_START;
            r_gnt      <= 4'b0001 << w_winner;
            r_last     <= w_winner;
            r_tx_start <= 1'b1;
            r_tx_data  <= w_byte;
            r_active   <= 1'b1;
          end
        end
        S_START: begin
          r_state <= S_WAIT;
          r_cnt   <= 16'd0;
        end
        S_WAIT: begin
          // A completion arriving on the timeout cycle still counts as success.
          if (tx_end) begin
            r_state <= S_DONE;
            r_gnt   <= 4'b0000;
            r_done  <= r_gnt;
          end else if (r_cnt == c_TMO_LAST) begin
            r_state <= S_DONE;
            r_gnt   <= 4'b0000;
            r_err   <= r_gnt;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end
        S_DONE: begin
          r_state  <= S_IDLE;
          r_active <= 1'b0;
        end
        default: begin
          r_state  <= S_IDLE;
          r_gnt    <= 4'b0000;
          r_active <= 1'b0;
        end
      endcase
    end
  end

  assign gnt      = r_gnt;
  assign done     = r_done;
  assign err      = r_err;
  assign active   = r_active;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_sched
// Function : Directed and random stimulus for two scheduler instances
//            (default and short timeout) against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        en = 1'b0;
  logic        tx_busy = 1'b0;
  logic        tx_end = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [31:0] req_data = 32'h0;

  logic [3:0]  gnt_a, done_a, err_a, gnt_b, done_b, err_b;
  logic        active_a, active_b, tx_start_a, tx_start_b;
  logic [7:0]  tx_data_a, tx_data_b;

  int n_checks = 0;
  int n_pass   = 0;

  // Model per instance: owner (-1 none), cycles since grant, completion kind, last owner.
  int         m_own[2];
  int         m_age[2];
  int         m_out[2];
  int         m_fown[2];
  int         m_last[2];
  logic [7:0] m_byte[2];
  int         m_to[2] = '{50000, 8};

  always #5 clk = ~clk;

  uart_tx_sched u_dut_a (
    .clk(clk), .reset(reset), .en(en), .req(req), .req_data(req_data),
    .gnt(gnt_a), .done(done_a), .err(err_a), .active(active_a),
    .tx_busy(tx_busy), .tx_end(tx_end), .tx_start(tx_start_a), .tx_data(tx_data_a)
  );

  uart_tx_sched #(.TIMEOUT(16'd8)) u_dut_b (
    .clk(clk), .reset(reset), .en(en), .req(req), .req_data(req_data),
    .gnt(gnt_b), .done(done_b), .err(err_b), .active(active_b),
    .tx_busy(tx_busy), .tx_end(tx_end), .tx_start(tx_start_b), .tx_data(tx_data_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset(input int k);
    m_own[k]  = -1;
    m_age[k]  = 0;
    m_out[k]  = 0;
    m_fown[k] = 0;
    m_last[k] = 3;
    m_byte[k] = 8'h00;
  endtask

  task automatic model_step(input int k);
    int c;
    if (m_out[k] != 0) begin
      m_out[k] = 0;
    end else if (m_own[k] < 0) begin
      if (en && !tx_busy && req != 4'b0000) begin
        for (int n = 1; n <= 4; n++) begin
          c = (m_last[k] + n) % 4;
          if (req[c]) begin
            m_own[k] = c;
            break;
          end
        end
        m_last[k] = m_own[k];
        m_age[k]  = 0;
        m_byte[k] = req_data[8*m_own[k] +: 8];
      end
    end else if (m_age[k] == 0) begin
      m_age[k] = 1;
    end else if (tx_end) begin
      m_out[k] = 1; m_fown[k] = m_own[k]; m_own[k] = -1;
    end else if (m_age[k] == m_to[k]) begin
      m_out[k] = 2; m_fown[k] = m_own[k]; m_own[k] = -1;
    end else begin
      m_age[k]++;
    end
  endtask

  function automatic logic [31:0] e_gnt(input int k);
    return (m_own[k] >= 0) ? 32'(1 << m_own[k]) : 32'd0;
  endfunction
  function automatic logic [31:0] e_start(input int k);
    return (m_own[k] >= 0 && m_age[k] == 0) ? 32'd1 : 32'd0;
  endfunction
  function automatic logic [31:0] e_data(input int k);
    return (m_own[k] >= 0 && m_age[k] == 0) ? 32'(m_byte[k]) : 32'd0;
  endfunction
  function automatic logic [31:0] e_done(input int k);
    return (m_out[k] == 1) ? 32'(1 << m_fown[k]) : 32'd0;
  endfunction
  function automatic logic [31:0] e_err(input int k);
    return (m_out[k] == 2) ? 32'(1 << m_fown[k]) : 32'd0;
  endfunction
  function automatic logic [31:0] e_active(input int k);
    return (m_own[k] >= 0 || m_out[k] != 0) ? 32'd1 : 32'd0;
  endfunction

  task automatic compare_all();
    chk("gnt_a",      32'(gnt_a),      e_gnt(0));
    chk("done_a",     32'(done_a),     e_done(0));
    chk("err_a",      32'(err_a),      e_err(0));
    chk("active_a",   32'(active_a),   e_active(0));
    chk("tx_start_a", 32'(tx_start_a), e_start(0));
    chk("tx_data_a",  32'(tx_data_a),  e_data(0));
    chk("gnt_b",      32'(gnt_b),      e_gnt(1));
    chk("done_b",     32'(done_b),     e_done(1));
    chk("err_b",      32'(err_b),      e_err(1));
    chk("active_b",   32'(active_b),   e_active(1));
    chk("tx_start_b", 32'(tx_start_b), e_start(1));
    chk("tx_data_b",  32'(tx_data_b),  e_data(1));
  endtask

  task automatic step();
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!reset) model_reset(k);
      else        model_step(k);
    end
    #1;
    compare_all();
  endtask

  task automatic wait_start(input int k, input string tag);
    int n;
    n = 0;
    while (((k == 0) ? tx_start_a : tx_start_b) !== 1'b1 && n < 30) begin
      step();
      n++;
    end
    chk({tag, "_start_seen"}, 32'((k == 0) ? tx_start_a : tx_start_b), 32'd1);
  endtask

  initial begin
    int w;
    int n;
    model_reset(0);
    model_reset(1);

    // Reset state
    repeat (3) step();
    chk("rst_gnt", 32'(gnt_a), 32'd0);
    chk("rst_data", 32'(tx_data_a), 32'd0);
    chk("rst_active", 32'(active_a), 32'd0);
    reset = 1'b1;
    en    = 1'b1;
    step();

    // Single transfer from requester 2, completion 10 cycles after start
    req_data = {8'h11, 8'hA5, 8'h22, 8'h33};
    req      = 4'b0100;
    wait_start(0, "single");
    chk("single_gnt", 32'(gnt_a), 32'h4);
    chk("single_data", 32'(tx_data_a), 32'hA5);
    repeat (9) step();
    tx_end = 1'b1;
    step();
    tx_end = 1'b0;
    chk("single_done", 32'(done_a), 32'h4);
    chk("single_err", 32'(err_a), 32'h0);
    req = 4'b0000;
    repeat (3) step();

    // Gating by tx_busy, then by en
    req     = 4'b0001;
    tx_busy = 1'b1;
    repeat (3) begin
      step();
      chk("gate_busy_gnt", 32'(gnt_a), 32'd0);
      chk("gate_busy_start", 32'(tx_start_a), 32'd0);
    end
    tx_busy = 1'b0;
    en      = 1'b0;
    repeat (3) begin
      step();
      chk("gate_en_gnt", 32'(gnt_b), 32'd0);
    end
    en = 1'b1;
    step();
    chk("gate_release_gnt", 32'(gnt_a), 32'h1);
    chk("gate_release_start", 32'(tx_start_b), 32'd1);
    step();
    step();
    tx_end = 1'b1;
    step();
    tx_end = 1'b0;
    req    = 4'b0000;
    repeat (2) step();

    // Round-robin from a fresh reset with all four requesting
    reset = 1'b0;
    step();
    reset    = 1'b1;
    req_data = $urandom;
    req      = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      w = i % 4;
      wait_start(0, "rr");
      chk("rr_gnt", 32'(gnt_a), 32'(1 << w));
      chk("rr_data", 32'(tx_data_a), 32'(req_data[8*w +: 8]));
      step();
      step();
      tx_end = 1'b1;
      step();
      tx_end = 1'b0;
      chk("rr_done", 32'(done_a), 32'(1 << w));
    end
    req = 4'b0000;
    repeat (2) step();

    // Timeout on the short-timeout instance
    req = 4'b0001;
    wait_start(1, "tmo");
    n = 0;
    while (err_b == 4'b0000 && n < 20) begin
      step();
      n++;
    end
    chk("tmo_cycles", 32'(n), 32'd9);
    chk("tmo_err", 32'(err_b), 32'h1);
    chk("tmo_nodone", 32'(done_b), 32'h0);
    req = 4'b0000;
    step();
    step();
    chk("tmo_idle", 32'(active_b), 32'd0);
    tx_end = 1'b1;
    step();
    tx_end = 1'b0;
    chk("tmo_a_done", 32'(done_a), 32'h1);
    repeat (3) step();

    // tx_end on the same cycle the counter reaches TIMEOUT-1
    req = 4'b0010;
    wait_start(1, "col");
    repeat (8) step();
    tx_end = 1'b1;
    step();
    tx_end = 1'b0;
    chk("col_done", 32'(done_b), 32'h2);
    chk("col_err", 32'(err_b), 32'h0);
    req = 4'b0000;
    repeat (3) step();

    // Asynchronous reset while waiting
    req = 4'b1000;
    wait_start(0, "rst");
    repeat (3) step();
    #3;
    reset = 1'b0;
    #1;
    model_reset(0);
    model_reset(1);
    compare_all();
    chk("arst_gnt", 32'(gnt_a), 32'd0);
    chk("arst_active", 32'(active_b), 32'd0);
    #2;
    reset = 1'b1;
    step();
    chk("arst_regrant_a", 32'(gnt_a), 32'h8);
    chk("arst_regrant_b", 32'(gnt_b), 32'h8);
    step();
    step();
    tx_end = 1'b1;
    step();
    tx_end = 1'b0;
    req = 4'b0000;
    repeat (2) step();

    // Random traffic
    repeat (400) begin
      en      = ($urandom % 8) != 0;
      tx_busy = ($urandom % 5) == 0;
      tx_end  = ($urandom % 6) == 0;
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && ($urandom % 3) == 0) begin
          req[i] = 1'b1;
          req_data[8*i +: 8] = 8'($urandom);
        end else if (req[i] && ($urandom % 10) == 0) begin
          req[i] = 1'b0;
        end
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 Parameter TIMEOUT, default 16'd50000, WAIT-state cycle limit before abort; range 1..65535.
REQ-002 Port clk  input  1  system clock; all state on its rising edge.
REQ-003 Port reset  input  1  asynchronous reset, active-low: reset==0 clears state immediately, regardless of clk.
REQ-004 Port en  input  1  scheduler enable; 0 blocks new grants.
REQ-005 Port req  input  4  per-requester transmit request, held high until that requester's done pulse.
REQ-006 Port req_data  input  32  requester i byte on bits [8i+7:8i]; stable while req[i]=1.
REQ-007 Port gnt  output  4  one-hot, requester currently owning the UART transmitter.
REQ-008 Port done  output  4  one-cycle pulse to owner on successful byte completion.
REQ-009 Port err  output  4  one-cycle pulse to owner on timeout abort.
REQ-010 Port active  output  1  high in any state other than IDLE.
REQ-011 Port tx_busy  input  1  UART transmitter busy.
REQ-012 Port tx_end  input  1  UART transmitter one-cycle end-of-byte pulse.
REQ-013 Port tx_start  output  1  one-cycle start pulse to UART transmitter.
REQ-014 Port tx_data  output  8  byte to UART transmitter; 8'h00 when tx_start=0.

Function
REQ-015 FSM states IDLE, START, WAIT, DONE; all outputs registered.
REQ-016 IDLE -> START when en=1, tx_busy=0 and req!=0; winner chosen, gnt set one-hot, winner's byte latched internally.
REQ-017 Arbitration round-robin: search order starts at (last_owner+1) mod 4; last_owner updates on each grant.
REQ-018 After reset last_owner=3, so requester 0 has highest priority first.
REQ-019 START: tx_start=1 and tx_data=latched byte for exactly one cycle; next state WAIT; timeout counter cleared to 0.
REQ-020 WAIT: counter increments by 1 per cycle; tx_end=1 -> DONE with success; counter==TIMEOUT-1 and tx_end=0 -> DONE with error.
REQ-021 tx_end and timeout in the same cycle: tx_end wins, success.
REQ-022 DONE (one cycle): done[owner]=1 on success or err[owner]=1 on error, gnt cleared, next state IDLE.
REQ-023 Latency: grant-to-tx_start 1 cycle; tx_end-to-done 1 cycle; done to next grant at least 1 cycle (IDLE visited).
REQ-024 Owner dropping req mid-transfer: transfer continues unchanged; done/err still pulses.
REQ-025 en=0 mid-transfer: current transfer completes normally; no new grant until en=1.
REQ-026 tx_busy=1 in IDLE: no grant issued; requests stay pending.
REQ-027 Requests arriving during START/WAIT/DONE are not lost; arbitrated on next IDLE cycle.
REQ-028 tx_end pulses outside WAIT are ignored.
REQ-029 At most one of gnt, done, err bits asserted at any time; done and err never in the same cycle.

Reset
REQ-030 reset==0 forces state IDLE, gnt=0, done=0, err=0, active=0, tx_start=0, tx_data=8'h00, counter=0, last_owner=3, latched byte=8'h00.
REQ-031 Reset asserted mid-transfer aborts immediately; no done/err pulse is produced; first post-reset arbitration starts at requester 0.

Verification
REQ-032 Single: en=1, req=4'b0100, req_data[23:16]=8'hA5; tx_end 10 cycles after tx_start -> gnt=4'b0100, tx_start with tx_data=8'hA5, done=4'b0100 one cycle after tx_end.
REQ-033 Round-robin: req=4'b1111 held after each done -> grant order 0,1,2,3,0; each tx_data matches the requester byte.
REQ-034 Timeout: TIMEOUT=8, no tx_end -> err[owner]=1 exactly 8 cycles after WAIT entry (9 after tx_start); no done; FSM returns to IDLE.
REQ-035 Collision: tx_end on the same cycle counter reaches TIMEOUT-1 -> done pulses, err stays 0.
REQ-036 Gating: tx_busy=1 or en=0 with req=4'b0001 -> no gnt, no tx_start; deassert both -> grant next cycle.
REQ-037 Reset in WAIT: reset==0 pulse -> all outputs to reset values asynchronously; no done/err; with req=4'b1000 still high, it is granted after reset release.
